fm0_decoder: RTL and testbench
==============================

# fm0_decoder

Baseband FM0 decoder sitting directly downstream of the preamble detector. It consumes the aligned, oversampled chip stream (`in_dat`/`in_vld`), the `preamble_detected`/`postamble_detected` pulses and the selected `frequency_bank`. It recovers tag data bits by classifying run lengths between transitions, then emits one `bit_vld` pulse per decoded bit plus a frame-done/error summary for the frame assembler.

## Interface
- `BANKS`, 4: number of frequency banks; must match the detector.
- `HALF_BASE`, 8: samples per half-symbol for bank 0.
- `HALF_STEP`, 2: extra samples per half-symbol per bank index.
- `RUN_WIDTH`, 8: run-length counter width.
- `COUNT_WIDTH`, 12: decoded-bit counter width.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_dat` in 1: oversampled chip from the detector FIFO.
- `in_vld` in 1: `in_dat` qualifier; gaps are allowed.
- `start` in 1: one-cycle pulse, tied to `preamble_detected`.
- `stop` in 1: one-cycle pulse, tied to `postamble_detected`.
- `frequency_bank` in $clog2(BANKS): bank index, sampled on `start`.
- `bit_dat` out 1: decoded bit.
- `bit_vld` out 1: one-cycle qualifier for `bit_dat`.
- `bit_count` out COUNT_WIDTH: bits decoded in the current or last frame.
- `frame_done` out 1: one-cycle pulse at the end of a frame.
- `frame_err` out 1: sticky coding-violation flag; cleared on `start`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- On `start`, latch `H = HALF_BASE + frequency_bank*HALF_STEP` (RUN_WIDTH bits). Derive the thresholds from `H`:
  - `GLITCH = H>>1`
  - `SHORT_MAX = H + (H>>1)`
  - `LONG_MAX = 2H + (H>>1)`
- Run tracking applies to valid samples only:
  - Sample equal to `prev`: `run` increments, saturating at all ones.
  - Sample differing from `prev` (a transition): classify `run`, then set `run = 1` and `prev = sample`.
- Run classification:
  - `run < GLITCH`: glitch.
  - `run <= SHORT_MAX`: short.
  - `run <= LONG_MAX`: long.
  - Otherwise: over-length.
- State machine:
  - IDLE: wait for `start`. On `start`, go to SYNC, clear `bit_count`/`frame_err`/`run`, and load `prev` from the concurrent sample if one is valid.
  - SYNC: the first run is partial. At the first transition, discard the classification and go to DATA.
  - DATA:
    - Long: emit 1, stay in DATA.
    - Short: go to MID.
    - Glitch or over-length: violation.
  - MID:
    - Short: emit 0, return to DATA.
    - Anything else: violation.
  - Violation: set `frame_err`, pulse `frame_done`, go to IDLE.
- Timeout: in SYNC, DATA or MID, if `run` reaches `LONG_MAX+1` with no transition, this marks the end of the carrier. Pulse `frame_done` and go to IDLE. This is not an error, except in MID, where it also sets `frame_err`.
- `stop` in any non-IDLE state: pulse `frame_done` and go to IDLE. A half-bit pending in MID is dropped without error.
- `bit_count` increments on each emitted bit and saturates at all ones. It holds its value in IDLE until the next `start`.

## Timing
- Reset state:
  - All outputs are 0.
  - State is IDLE; `run`, `prev` and `H` are 0.
- `bit_vld`, `bit_dat`, `frame_done` and `bit_count` are registered. They update one cycle after the `in_vld` sample (or `stop`) that causes them.
- `start` has priority over everything. `start` in a non-IDLE state restarts the frame with no `frame_done` for the aborted frame.
- A transition that emits a bit in the same cycle as `stop`: the bit is emitted and `frame_done` pulses on the same output cycle.
- `start` and `stop` in the same cycle: `start` wins.
- `in_vld` low: no counter or state change; timeouts count valid samples only.
- `frame_done` and `bit_vld` are never high for more than one consecutive cycle per event.
- Asynchronous reset mid-frame: everything returns to reset values immediately, with no `frame_done`.

## Test plan
- Reset: assert `rst_n=0` mid-stream. All outputs go to 0 immediately; after release, `busy=0`.
- Basic decode, bank 0 (`H=8`, `SHORT_MAX=12`, `LONG_MAX=20`):
  - Stimulus: `start`, then 5×1, 16×0, 8×1, 8×0, 16×1, 21×0.
  - Response: bits 1,0,1; `frame_done` one cycle after the 21st zero; `bit_count=3`; `frame_err=0`.
- Bank 3 (`H=14`): `start`, 3×1, then runs of 28,14,14,28 followed by a 36-sample run. Response: bits 1,0,1; `frame_done`.
- Violation: bank 0, after sync feed a short run of 8 then a long run of 16. Response: no bit emitted, `frame_err=1`, `frame_done` pulse, `busy=0`.
- Glitch and gaps:
  - Glitch: a run of 2 in DATA gives `frame_err=1`.
  - Gaps: the same stream as the basic-decode test with random `in_vld` gaps gives an identical bit sequence.
- `stop` mid-MID drops the pending half-bit, pulses `frame_done` with `frame_err=0`. `start` with `stop` in the same cycle starts a frame and leaves `busy=1`.

Source files
------------

// File: rtl/fm0_decoder.sv
// FM0 run-length decoder: classifies runs between transitions into half/full symbols and emits bits.
// Outputs registered, one cycle after the causing sample or stop; no backpressure (in_vld gaps just pause it).
module fm0_decoder #(
  parameter int BANKS       = 4,
  parameter int HALF_BASE   = 8,
  parameter int HALF_STEP   = 2,
  parameter int RUN_WIDTH   = 8,
  parameter int COUNT_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_dat,
  input  logic                       in_vld,
  input  logic                       start,
  input  logic                       stop,
  input  logic [$clog2(BANKS)-1:0]   frequency_bank,
  output logic                       bit_dat,
  output logic                       bit_vld,
  output logic [COUNT_WIDTH-1:0]     bit_count,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int TW = RUN_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_MID} state_t;

  state_t                 r_state;
  logic [RUN_WIDTH-1:0]   r_h;
  logic [RUN_WIDTH-1:0]   r_run;
  logic                   r_prev;
  logic                   r_bit_dat;
  logic                   r_bit_vld;
  logic [COUNT_WIDTH-1:0] r_bit_count;
  logic                   r_frame_done;
  logic                   r_frame_err;

  logic [RUN_WIDTH-1:0]   w_h_start;
  logic [TW-1:0]          w_hx;
  logic [TW-1:0]          w_glitch;
  logic [TW-1:0]          w_short_max;
  logic [TW-1:0]          w_long_max;
  logic [TW-1:0]          w_runx;
  logic [RUN_WIDTH-1:0]   w_run_inc;
  logic                   w_same;
  logic                   w_timeout;
  logic                   w_is_glitch;
  logic                   w_is_short;
  logic                   w_is_long;
  logic                   w_emit;
  logic                   w_emit_dat;
  logic                   w_done;
  logic                   w_err;
  state_t                 w_nstate;

  assign w_h_start   = RUN_WIDTH'(HALF_BASE + int'(frequency_bank) * HALF_STEP);
  assign w_hx        = TW'(r_h);
  assign w_glitch    = w_hx >> 1;
  assign w_short_max = w_hx + (w_hx >> 1);
  assign w_long_max  = (w_hx << 1) + (w_hx >> 1);
  assign w_runx      = TW'(r_run);
  assign w_run_inc   = (&r_run) ? r_run : r_run + 1'b1;
  assign w_same      = (in_dat == r_prev);
  // Run would reach LONG_MAX+1 on this sample: carrier has ended.
  assign w_timeout   = TW'(w_run_inc) > w_long_max;
  assign w_is_glitch = w_runx < w_glitch;
  assign w_is_short  = !w_is_glitch && (w_runx <= w_short_max);
  assign w_is_long   = !w_is_glitch && !w_is_short && (w_runx <= w_long_max);

  always_comb begin
    w_emit     = 1'b0;
    w_emit_dat = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_nstate   = r_state;
    if (r_state != S_IDLE && in_vld) begin
      if (w_same) begin
        if (w_timeout) begin
          w_done   = 1'b1;
          w_err    = (r_state == S_MID);
          w_nstate = S_IDLE;
        end
      end else begin
        case (r_state)
          S_SYNC: w_nstate = S_DATA;
          S_DATA: begin
            if (w_is_long) begin
              w_emit     = 1'b1;
              w_emit_dat = 1'b1;
            end else if (w_is_short) begin
              w_nstate = S_MID;
            end else begin
              w_err    = 1'b1;
              w_done   = 1'b1;
              w_nstate = S_IDLE;
            end
          end
          S_MID: begin
            if (w_is_short) begin
              w_emit   = 1'b1;
              w_nstate = S_DATA;
            end else begin
              w_err    = 1'b1;
              w_done   = 1'b1;
              w_nstate = S_IDLE;
            end
          end
          default: w_nstate = S_IDLE;
        endcase
      end
    end
    // A bit completed alongside stop is still emitted; only the pending half-bit is lost.
    if (r_state != S_IDLE && stop) begin
      w_done   = 1'b1;
      w_nstate = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_h          <= '0;
      r_run        <= '0;
      r_prev       <= 1'b0;
      r_bit_dat    <= 1'b0;
      r_bit_vld    <= 1'b0;
      r_bit_count  <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_bit_vld    <= 1'b0;
      r_frame_done <= 1'b0;
      if (start) begin
        r_state     <= S_SYNC;
        r_h         <= w_h_start;
        r_run       <= '0;
        r_bit_count <= '0;
        r_frame_err <= 1'b0;
        if (in_vld) r_prev <= in_dat;
      end else if (r_state != S_IDLE) begin
        r_state      <= w_nstate;
        r_bit_vld    <= w_emit;
        r_frame_done <= w_done;
        if (w_emit) begin
          r_bit_dat <= w_emit_dat;
          if (!(&r_bit_count)) r_bit_count <= r_bit_count + 1'b1;
        end
        if (w_err) r_frame_err <= 1'b1;
        if (in_vld) begin
          if (w_same) begin
            r_run <= w_run_inc;
          end else begin
            r_run  <= RUN_WIDTH'(1);
            r_prev <= in_dat;
          end
        end
      end
    end
  end

  assign bit_dat    = r_bit_dat;
  assign bit_vld    = r_bit_vld;
  assign bit_count  = r_bit_count;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fm0_decoder.sv
// Bench for fm0_decoder: frames described as run-length lists, expected bits derived from FM0 run rules.
module tb_fm0_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_dat = 1'b0;
  logic        in_vld = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  frequency_bank = 2'd0;
  logic        bit_dat;
  logic        bit_vld;
  logic [11:0] bit_count;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int got_bits[$];
  int done_cnt = 0;
  int done_at = -1;

  int m_runs[$];
  int m_first;
  bit m_samp[$];
  int exp_bits[$];
  bit exp_err;
  int exp_end;

  fm0_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_dat(in_dat), .in_vld(in_vld),
    .start(start), .stop(stop), .frequency_bank(frequency_bank),
    .bit_dat(bit_dat), .bit_vld(bit_vld), .bit_count(bit_count),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bit_vld) got_bits.push_back(int'(bit_dat));
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_at  = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // FM0 rules over whole runs: first run is partial, long = 1, short+short = 0.
  function automatic void model(input int h);
    int g    = h / 2;
    int smax = h + h / 2;
    int lmax = 2 * h + h / 2;
    int idx  = 0;
    bit half = 1'b0;
    exp_bits.delete();
    exp_err = 1'b0;
    exp_end = -1;
    for (int i = 0; i < m_runs.size(); i++) begin
      int len = m_runs[i];
      if (i == 0) begin
        if (len >= lmax + 2) begin exp_end = lmax + 1; return; end
      end else begin
        if (len >= lmax + 1) begin exp_end = idx + lmax; exp_err = half; return; end
        if (i == m_runs.size() - 1) return;
        if (len < g) begin exp_err = 1'b1; exp_end = idx + len; return; end
        if (!half) begin
          if (len > smax) exp_bits.push_back(1);
          else half = 1'b1;
        end else if (len <= smax) begin
          exp_bits.push_back(0);
          half = 1'b0;
        end else begin
          exp_err = 1'b1; exp_end = idx + len; return;
        end
      end
      idx += len;
    end
  endfunction

  function automatic void expand();
    bit v = m_first[0];
    m_samp.delete();
    foreach (m_runs[i]) begin
      for (int k = 0; k < m_runs[i]; k++) m_samp.push_back(v);
      v = ~v;
    end
  endfunction

  // Drives samples 0..last; sample 0 carries start. Returns the cycle stamp of sample 'last'.
  task automatic feed(input int bank, input int last, input bit gaps, output int end_at);
    end_at = -1;
    for (int s = 0; s <= last && s < m_samp.size(); s++) begin
      if (gaps && s > 0) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          start = 1'b0; in_vld = 1'b0; in_dat = 1'($urandom);
        end
      end
      @(negedge clk);
      in_vld = 1'b1;
      in_dat = m_samp[s];
      start  = (s == 0);
      frequency_bank = 2'(bank);
      end_at = cyc;
    end
    @(negedge clk);
    in_vld = 1'b0; start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int bank, input bit gaps);
    int bits_base = got_bits.size();
    int done_base = done_cnt;
    int end_at;
    int n;
    expand();
    model(8 + 2 * bank);
    feed(bank, exp_end, gaps, end_at);
    for (int w = 0; w < 8 && done_cnt == done_base; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, done_cnt - done_base, 1);
    chk({tag, "_done_lat"}, done_at, end_at + 1);
    n = got_bits.size() - bits_base;
    chk({tag, "_nbits"}, n, exp_bits.size());
    for (int i = 0; i < n && i < exp_bits.size(); i++)
      chk({tag, "_bit"}, got_bits[bits_base + i], exp_bits[i]);
    chk({tag, "_count"}, int'(bit_count), exp_bits.size());
    chk({tag, "_err"}, int'(frame_err), int'(exp_err));
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int base;
    int dbase;
    int end_at;
    int h;
    int lmax;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_outputs", int'({bit_dat, bit_vld, frame_done, frame_err, busy}), 0);
    chk("rst_count", int'(bit_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);

    m_first = 1; m_runs = '{5, 16, 8, 8, 16, 21};
    base = got_bits.size();
    run_frame("basic", 0, 1'b0);
    chk("basic_b0", got_bits[base], 1);
    chk("basic_b1", got_bits[base + 1], 0);
    chk("basic_b2", got_bits[base + 2], 1);
    chk("basic_cnt3", int'(bit_count), 3);

    run_frame("gaps", 0, 1'b1);

    m_first = 1; m_runs = '{3, 28, 14, 14, 28, 36};
    run_frame("bank3", 3, 1'b0);

    m_first = 1; m_runs = '{5, 8, 16, 1};
    run_frame("viol", 0, 1'b0);
    chk("viol_err1", int'(frame_err), 1);

    m_first = 0; m_runs = '{5, 16, 2, 1};
    run_frame("glitch", 0, 1'b0);
    chk("glitch_err1", int'(frame_err), 1);

    for (int f = 0; f < 8; f++) begin
      int bank = $urandom_range(0, 3);
      int nr = $urandom_range(3, 10);
      h = 8 + 2 * bank;
      lmax = 2 * h + h / 2;
      m_first = $urandom_range(0, 1);
      m_runs.delete();
      m_runs.push_back($urandom_range(1, 5));
      for (int r = 0; r < nr; r++) begin
        if ($urandom_range(0, 3) == 0) m_runs.push_back($urandom_range(1, lmax + 1));
        else if ($urandom_range(0, 1) == 0) m_runs.push_back(h + $urandom_range(0, 2) - 1);
        else m_runs.push_back(2 * h + $urandom_range(0, 2) - 1);
      end
      m_runs.push_back(lmax + 2);
      run_frame("rand", bank, f[0]);
    end

    // stop while a half-bit is pending
    m_first = 1; m_runs = '{5, 16, 8, 4};
    expand();
    base = got_bits.size(); dbase = done_cnt;
    feed(0, 30, 1'b0, end_at);
    stop = 1'b1; end_at = cyc;
    @(negedge clk);
    stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("stopmid_nbits", got_bits.size() - base, 1);
    chk("stopmid_done", done_cnt - dbase, 1);
    chk("stopmid_lat", done_at, end_at + 1);
    chk("stopmid_err", int'(frame_err), 0);
    chk("stopmid_busy", int'(busy), 0);

    // start and stop together, then a restart while busy
    dbase = done_cnt;
    @(negedge clk);
    start = 1'b1; stop = 1'b1; in_vld = 1'b1; in_dat = 1'b0;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; in_vld = 1'b0;
    chk("startstop_busy", int'(busy), 1);
    start = 1'b1; in_vld = 1'b1;
    @(negedge clk);
    start = 1'b0; in_vld = 1'b0;
    @(negedge clk);
    chk("restart_busy", int'(busy), 1);
    chk("restart_nodone", done_cnt - dbase, 0);

    // asynchronous reset mid-frame
    m_first = 1; m_runs = '{5, 16, 8, 8, 16, 21};
    expand();
    feed(0, 24, 1'b0, end_at);
    chk("prerst_count", int'(bit_count), 1);
    dbase = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", int'({bit_dat, bit_vld, frame_done, frame_err, busy}), 0);
    chk("arst_count", int'(bit_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_busy", int'(busy), 0);
    chk("arst_nodone", done_cnt - dbase, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
